// File: rtl/sort_stream_if.sv
// Serial load/unload channel of sort_stream.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the source holds data stable until then.
interface sort_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_stream.sv
// Serial batch sorter: loads N values, sorts them in place with N phases of
// odd-even transposition, then streams them out in ascending order.
module sort_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sort_stream_if.slave s,
  output logic         busy,
  output logic [1:0]   state_dbg
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, UNLOAD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q      [N];
  logic [WIDTH-1:0] mem_sorted [N];
  logic [CW-1:0]    cnt_q, idx_q, phase_q;
  logic             load_hs, load_done, sort_done, out_hs, unload_done;

  assign load_hs     = (state_q == LOAD) && s.in_valid;
  assign load_done   = load_hs && (cnt_q == CW'(N - 1));
  assign sort_done   = (state_q == SORT) && (phase_q == CW'(N - 1));
  assign out_hs      = (state_q == UNLOAD) && s.out_ready;
  assign unload_done = out_hs && (idx_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done)   state_d = SORT;
      SORT:    if (sort_done)   state_d = UNLOAD;
      UNLOAD:  if (unload_done) state_d = LOAD;
      default:                  state_d = LOAD;
    endcase
  end

  always_comb begin
    s.in_ready  = (state_q == LOAD);
    s.out_valid = (state_q == UNLOAD);
    s.out_last  = (state_q == UNLOAD) && (idx_q == CW'(N - 1));
    s.out_data  = (state_q == UNLOAD) ? mem_q[idx_q] : '0;
    busy        = (state_q != LOAD);
    state_dbg   = state_q;
  end

  // One transposition phase: pairs are disjoint, so every swap reads the old buffer.
  always_comb begin
    for (int i = 0; i < N; i++) mem_sorted[i] = mem_q[i];
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(phase_q[0]) && (mem_q[i] > mem_q[i + 1])) begin
        mem_sorted[i]     = mem_q[i + 1];
        mem_sorted[i + 1] = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_hs) begin
            mem_q[cnt_q] <= s.in_data;
            cnt_q        <= load_done ? '0 : cnt_q + 1'b1;
            if (load_done) phase_q <= '0;
          end
        end
        SORT: begin
          for (int i = 0; i < N; i++) mem_q[i] <= mem_sorted[i];
          phase_q <= sort_done ? '0 : phase_q + 1'b1;
          if (sort_done) idx_q <= '0;
        end
        UNLOAD: begin
          if (out_hs) begin
            idx_q <= unload_done ? '0 : idx_q + 1'b1;
            if (unload_done) cnt_q <= '0;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sort_stream.sv
// Bench for sort_stream: directed and random batches checked against a
// queue-sort reference, plus handshake, latency and reset behaviour.
module tb_sort_stream;
  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;

  sort_stream_if #(.WIDTH(W)) bus ();

  sort_stream #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           last_q[$];
  bit           gap_q[$];
  bit           rdy_q[$];
  int           acc_edges[$];
  int           last_edges[$];
  int           lat_q[$];
  int           acc_total = 0;
  int           proto_err = 0;
  bit           lat_pend = 0;
  int           lat_edge = 0;

  // Reference model: the expected output of a batch is simply the batch sorted.
  task automatic push_batch(input logic [W-1:0] v[N]);
    logic [W-1:0] t[$];
    for (int i = 0; i < N; i++) begin
      src_q.push_back(v[i]);
      t.push_back(v[i]);
    end
    t.sort();
    foreach (t[i]) exp_q.push_back(t[i]);
  endtask

  task automatic clear_sb();
    src_q.delete(); exp_q.delete(); got_q.delete(); last_q.delete();
    gap_q.delete(); rdy_q.delete(); acc_edges.delete(); last_edges.delete();
    lat_q.delete();
    proto_err = 0;
    lat_pend  = 0;
  endtask

  // Cycle driver: observes at posedge+1, drives for the next edge, records beats.
  task automatic run(input int target, input int max_cyc, output bit timeout);
    bit v, r, stall, lastp, after;
    logic [W-1:0] pdata;
    stall = 0; after = 0; lastp = 0; pdata = '0;
    for (int c = 0; c < max_cyc && got_q.size() < target; c++) begin
      if (bus.in_ready !== ~busy) proto_err++;
      if (bus.out_valid && (!busy || bus.in_ready)) proto_err++;
      if (!bus.out_valid && bus.out_last) proto_err++;
      if (stall && (bus.out_valid !== 1'b1 || bus.out_data !== pdata || bus.out_last !== lastp))
        proto_err++;
      if (after && (bus.in_ready !== 1'b1 || busy !== 1'b0)) proto_err++;
      if (lat_pend && bus.out_valid) begin
        lat_q.push_back(edge_n + 1 - lat_edge);
        lat_pend = 0;
      end

      v = 1'b0;
      if (src_q.size() > 0) v = (gap_q.size() > 0) ? gap_q.pop_front() : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? src_q[0] : W'($urandom);
      if (bus.out_valid) r = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      else               r = 1'($urandom_range(0, 1));
      bus.out_ready = r;

      stall = bus.out_valid && !r;
      pdata = bus.out_data;
      lastp = bus.out_last;
      after = bus.out_valid && r && bus.out_last;
      if (after) last_edges.push_back(edge_n + 1);
      if (v && bus.in_ready) begin
        void'(src_q.pop_front());
        acc_edges.push_back(edge_n + 1);
        acc_total++;
        if (acc_total % N == 0) begin
          lat_pend = 1;
          lat_edge = edge_n + 1;
        end
      end
      if (bus.out_valid && r) begin
        got_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
      end
      @(posedge clk); #1;
    end
    timeout = (got_q.size() < target);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", bus.out_data); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle got in_ready=%b busy=%b exp 1/0", bus.in_ready, busy); end
    acc_total = 0;
  endtask

  task automatic test_basic();
    bit to;
    clear_sb();
    push_batch('{8'd13, 8'd1, 8'd23, 8'd10});
    run(N, 100, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got %0d beats exp %0d", got_q.size(), N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
      checks++; if (last_q[i] !== ((i % N) == N - 1)) begin errors++; $display("FAIL basic_last[%0d] got %b exp %b", i, last_q[i], (i % N) == N - 1); end
    end
    checks++; if (lat_q.size() < 1 || lat_q[0] !== N + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", (lat_q.size() > 0) ? lat_q[0] : -1, N + 1); end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL basic_protocol got %0d violations exp 0", proto_err); end
  endtask

  task automatic test_reverse();
    bit to;
    clear_sb();
    push_batch('{8'd255, 8'd200, 8'd100, 8'd0});
    run(N, 100, to);
    checks++; if (to) begin errors++; $display("FAIL reverse_timeout got %0d beats exp %0d", got_q.size(), N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reverse_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL reverse_protocol got %0d violations exp 0", proto_err); end
  endtask

  task automatic test_duplicates();
    bit to;
    clear_sb();
    push_batch('{8'd5, 8'd5, 8'd5, 8'd5});
    push_batch('{8'd7, 8'd3, 8'd7, 8'd3});
    run(2 * N, 200, to);
    checks++; if (to) begin errors++; $display("FAIL dup_timeout got %0d beats exp %0d", got_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL dup_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
      checks++; if (last_q[i] !== ((i % N) == N - 1)) begin errors++; $display("FAIL dup_last[%0d] got %b exp %b", i, last_q[i], (i % N) == N - 1); end
    end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL dup_protocol got %0d violations exp 0", proto_err); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_sb();
    push_batch('{8'd13, 8'd1, 8'd23, 8'd10});
    rdy_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run(N, 100, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got %0d beats exp %0d", got_q.size(), N); end
    checks++; if (got_q.size() !== N) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL bp_hold got %0d violations exp 0", proto_err); end
  endtask

  task automatic test_gaps();
    bit to;
    clear_sb();
    push_batch('{8'd9, 8'd4, 8'd6, 8'd2});
    gap_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run(N, 100, to);
    checks++; if (to) begin errors++; $display("FAIL gaps_timeout got %0d beats exp %0d", got_q.size(), N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (lat_q.size() < 1 || lat_q[0] !== N + 1) begin errors++; $display("FAIL gaps_latency got %0d exp %0d", (lat_q.size() > 0) ? lat_q[0] : -1, N + 1); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_sb();
    push_batch('{8'd13, 8'd1, 8'd23, 8'd10});
    run(2, 100, to);
    checks++; if (got_q.size() !== 2 || got_q[1] !== 8'd10) begin errors++; $display("FAIL rst_pre got %0d beats exp 2 ending in 10", got_q.size()); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid_unload got valid=%b last=%b busy=%b data=%0d in_ready=%b exp 0/0/0/0/1", bus.out_valid, bus.out_last, busy, bus.out_data, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 8'd99;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_total = 0;
    clear_sb();
    push_batch('{8'd8, 8'd7, 8'd6, 8'd5});
    run(N, 100, to);
    checks++; if (to) begin errors++; $display("FAIL rst_timeout got %0d beats exp %0d", got_q.size(), N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (lat_q.size() < 1 || lat_q[0] !== N + 1) begin errors++; $display("FAIL rst_latency got %0d exp %0d", (lat_q.size() > 0) ? lat_q[0] : -1, N + 1); end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_sb();
    push_batch('{8'd3, 8'd2, 8'd1, 8'd0});
    push_batch('{8'd9, 8'd8, 8'd7, 8'd6});
    run(2 * N, 200, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got %0d beats exp %0d", got_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (acc_edges.size() < N + 1 || last_edges.size() < 1 || acc_edges[N] !== last_edges[0] + 1) begin
      errors++; $display("FAIL b2b_reload got accept edge %0d exp %0d", (acc_edges.size() > N) ? acc_edges[N] : -1, (last_edges.size() > 0) ? last_edges[0] + 1 : -1);
    end
    checks++;
    if (acc_edges.size() < N + 1 || acc_edges[N] - acc_edges[0] !== 3 * N) begin
      errors++; $display("FAIL b2b_throughput got %0d cycles exp %0d", (acc_edges.size() > N) ? acc_edges[N] - acc_edges[0] : -1, 3 * N);
    end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL b2b_protocol got %0d violations exp 0", proto_err); end
  endtask

  task automatic test_random();
    bit to;
    logic [W-1:0] v[N];
    int nb;
    clear_sb();
    nb = 6;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < N; i++)
        v[i] = (b % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
      push_batch(v);
    end
    for (int i = 0; i < 60; i++) gap_q.push_back($urandom_range(0, 9) < 7);
    for (int i = 0; i < 40; i++) rdy_q.push_back($urandom_range(0, 9) < 6);
    run(nb * N, 800, to);
    checks++; if (to) begin errors++; $display("FAIL rand_timeout got %0d beats exp %0d", got_q.size(), nb * N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
      checks++; if (last_q[i] !== ((i % N) == N - 1)) begin errors++; $display("FAIL rand_last[%0d] got %b exp %b", i, last_q[i], (i % N) == N - 1); end
    end
    foreach (lat_q[i]) begin
      checks++; if (lat_q[i] !== N + 1) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat_q[i], N + 1); end
    end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL rand_protocol got %0d violations exp 0", proto_err); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
